// File: rtl/mult_arb_pkg.sv
// Shared types and widths for the round-robin multiplier arbiter.
package mult_arb_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam int DEF_NUM_REQ = 4;
    localparam int OP_W        = 32;
    localparam int PROD_W      = 64;
endpackage

// File: rtl/mult32x32_arbiter_if.sv
// Requester-facing bus of the arbiter: packed request operands plus response path.
interface mult32x32_arbiter_if
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ*OP_W-1:0] req_a;
    logic [NUM_REQ*OP_W-1:0] req_b;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ-1:0]      resp_valid;
    logic [PROD_W-1:0]       resp_product;
    logic [IDX_W-1:0]        resp_idx;
    logic                    arb_busy;

    modport master (
        output req_valid, req_a, req_b,
        input  req_ready, resp_valid, resp_product, resp_idx, arb_busy
    );

    modport slave (
        input  req_valid, req_a, req_b,
        output req_ready, resp_valid, resp_product, resp_idx, arb_busy
    );
endinterface

// File: rtl/mult32x32.sv
// Iterative shift-add unsigned 32x32 multiplier; busy stays high for 32 cycles after start.
module mult32x32
    import mult_arb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              busy,
    output logic [PROD_W-1:0] product
);
    logic              r_busy;
    logic [4:0]        r_cnt;
    logic [PROD_W-1:0] r_mcand;
    logic [OP_W-1:0]   r_mplier;
    logic [PROD_W-1:0] r_acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (start && !r_busy) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_mcand  <= {{(PROD_W-OP_W){1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
        end else if (r_busy) begin
            if (r_mplier[0])
                r_acc <= r_acc + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 5'd1;
            if (r_cnt == 5'd31)
                r_busy <= 1'b0;
        end
    end

    assign busy    = r_busy;
    assign product = r_acc;
endmodule

// File: rtl/mult32x32_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after the pointer, wrapping.
module rr_picker
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
)(
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               grant_any,
    output logic [IDX_W-1:0]   grant_idx
);
    int w_j;

    // Walk offsets from farthest to nearest so the nearest set bit wins.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        w_j       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_j = (int'(rr_ptr) + k) % NUM_REQ;
            if (req_valid[w_j]) begin
                grant_any = 1'b1;
                grant_idx = IDX_W'(w_j);
            end
        end
    end
endmodule

// File: rtl/mult32x32_arbiter.sv
// Shares one iterative mult32x32 among NUM_REQ requesters with round-robin arbitration.
module mult32x32_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = $clog2(NUM_REQ)
)(
    input  logic                clk,
    input  logic                reset,
    mult32x32_arbiter_if.slave  bus
);
    arb_state_t        r_state, w_next;
    logic [IDX_W-1:0]  r_rr_ptr;
    logic [IDX_W-1:0]  r_win_idx;
    logic [OP_W-1:0]   r_op_a;
    logic [OP_W-1:0]   r_op_b;
    logic              r_busy_seen;
    logic [PROD_W-1:0] r_resp_product;
    logic [IDX_W-1:0]  r_resp_idx;

    logic              w_grant_any;
    logic [IDX_W-1:0]  w_grant_idx;
    logic              w_mult_start;
    logic              w_mult_busy;
    logic [PROD_W-1:0] w_mult_product;
    logic              w_run_exit;
    logic [NUM_REQ-1:0] w_win_onehot;

    rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
        .req_valid (bus.req_valid),
        .rr_ptr    (r_rr_ptr),
        .grant_any (w_grant_any),
        .grant_idx (w_grant_idx)
    );

    mult32x32 u_mult (
        .clk     (clk),
        .reset   (reset),
        .start   (w_mult_start),
        .a       (r_op_a),
        .b       (r_op_b),
        .busy    (w_mult_busy),
        .product (w_mult_product)
    );

    // busy_seen guards against leaving RUN before the multiplier has raised busy.
    assign w_run_exit = r_busy_seen && !w_mult_busy;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_grant_any) w_next = START;
            START:   w_next = RUN;
            RUN:     if (w_run_exit) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr       <= '0;
            r_win_idx      <= '0;
            r_op_a         <= '0;
            r_op_b         <= '0;
            r_busy_seen    <= 1'b0;
            r_resp_product <= '0;
            r_resp_idx     <= '0;
        end else begin
            case (r_state)
                IDLE: if (w_grant_any) begin
                    r_op_a    <= bus.req_a[int'(w_grant_idx)*OP_W +: OP_W];
                    r_op_b    <= bus.req_b[int'(w_grant_idx)*OP_W +: OP_W];
                    r_win_idx <= w_grant_idx;
                end
                START: r_busy_seen <= 1'b0;
                RUN: begin
                    if (w_mult_busy)
                        r_busy_seen <= 1'b1;
                    if (w_run_exit) begin
                        r_resp_product <= w_mult_product;
                        r_resp_idx     <= r_win_idx;
                    end
                end
                DONE: r_rr_ptr <= (r_win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : r_win_idx + 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_win_onehot            = '0;
        w_win_onehot[r_win_idx] = 1'b1;
    end

    assign w_mult_start     = (r_state == START);
    assign bus.req_ready    = (r_state == START) ? w_win_onehot : '0;
    assign bus.resp_valid   = (r_state == DONE)  ? w_win_onehot : '0;
    assign bus.arb_busy     = (r_state != IDLE);
    assign bus.resp_product = r_resp_product;
    assign bus.resp_idx     = r_resp_idx;
endmodule

// File: tb/tb_mult32x32_arbiter.sv
// Directed bench for mult32x32_arbiter: handshake timing, round-robin order, products, reset.
module tb_mult32x32_arbiter;
    import mult_arb_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    mult32x32_arbiter_if #(.NUM_REQ(4)) bus ();

    mult32x32_arbiter #(.NUM_REQ(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic set_req(input int slot, input logic [31:0] a, input logic [31:0] b);
        bus.req_a[slot*32 +: 32] = a;
        bus.req_b[slot*32 +: 32] = b;
    endtask

    task automatic wait_ready(output logic [3:0] rr, output bit ok);
        ok = 1'b0;
        rr = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.req_ready != 4'b0) begin
                rr = bus.req_ready;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_resp(output logic [3:0] rv, output bit ok);
        ok = 1'b0;
        rv = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus.resp_valid != 4'b0) begin
                rv = bus.resp_valid;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.req_valid = '0;
        reset = 1'b0;
        #1;
        total++; if (bus.req_ready !== 4'b0) begin bad++; $display("FAIL reset_req_ready got=%b want=0000", bus.req_ready); end
        total++; if (bus.resp_valid !== 4'b0) begin bad++; $display("FAIL reset_resp_valid got=%b want=0000", bus.resp_valid); end
        total++; if (bus.arb_busy !== 1'b0) begin bad++; $display("FAIL reset_arb_busy got=%b want=0", bus.arb_busy); end
        total++; if (bus.resp_product !== 64'd0) begin bad++; $display("FAIL reset_product got=%h want=0", bus.resp_product); end
        total++; if (bus.resp_idx !== 2'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", bus.resp_idx); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [3:0] rv;
        bit ok;
        set_req(0, 32'd3, 32'd5);
        bus.req_valid = 4'b0001;
        @(negedge clk);
        total++; if (bus.req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready got=%b want=0001", bus.req_ready); end
        total++; if (bus.arb_busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b want=1", bus.arb_busy); end
        bus.req_valid = '0;
        wait_resp(rv, ok);
        total++; if (!ok || rv !== 4'b0001) begin bad++; $display("FAIL single_resp_valid got=%b want=0001", rv); end
        total++; if (bus.resp_product !== 64'd15) begin bad++; $display("FAIL single_product got=%0d want=15", bus.resp_product); end
        total++; if (bus.resp_idx !== 2'd0) begin bad++; $display("FAIL single_idx got=%0d want=0", bus.resp_idx); end
        @(negedge clk);
        total++; if (bus.arb_busy !== 1'b0) begin bad++; $display("FAIL single_idle got=%b want=0", bus.arb_busy); end
        total++; if (bus.resp_valid !== 4'b0) begin bad++; $display("FAIL single_pulse got=%b want=0000", bus.resp_valid); end
        total++; if (bus.resp_product !== 64'd15) begin bad++; $display("FAIL single_hold got=%0d want=15", bus.resp_product); end
    endtask

    task automatic test_full_width();
        logic [3:0] rr, rv;
        bit ok;
        set_req(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        bus.req_valid = 4'b0100;
        wait_ready(rr, ok);
        bus.req_valid = '0;
        total++; if (!ok || rr !== 4'b0100) begin bad++; $display("FAIL full_ready got=%b want=0100", rr); end
        wait_resp(rv, ok);
        total++; if (!ok || rv !== 4'b0100) begin bad++; $display("FAIL full_resp_valid got=%b want=0100", rv); end
        total++; if (bus.resp_product !== 64'hFFFF_FFFE_0000_0001) begin bad++; $display("FAIL full_product got=%h want=fffffffe00000001", bus.resp_product); end
        total++; if (bus.resp_idx !== 2'd2) begin bad++; $display("FAIL full_idx got=%0d want=2", bus.resp_idx); end
    endtask

    task automatic test_simultaneous();
        logic [3:0]  rr, rv;
        bit          ok;
        int          order [5] = '{0, 1, 2, 3, 0};
        logic [63:0] prod  [4] = '{64'd14, 64'd100000, 64'h1_0000_0000, 64'h1_FFFF_FFFE};
        do_reset();
        set_req(0, 32'd2, 32'd7);
        set_req(1, 32'd100, 32'd1000);
        set_req(2, 32'h0001_0000, 32'h0001_0000);
        set_req(3, 32'hFFFF_FFFF, 32'd2);
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_ready(rr, ok);
            total++; if (!ok || rr !== (4'b1 << order[k])) begin bad++; $display("FAIL simul_grant%0d got=%b want=%b", k, rr, 4'b1 << order[k]); end
            wait_resp(rv, ok);
            total++; if (!ok || rv !== (4'b1 << order[k])) begin bad++; $display("FAIL simul_resp%0d got=%b want=%b", k, rv, 4'b1 << order[k]); end
            total++; if (bus.resp_idx !== 2'(order[k])) begin bad++; $display("FAIL simul_idx%0d got=%0d want=%0d", k, bus.resp_idx, order[k]); end
            total++; if (bus.resp_product !== prod[order[k]]) begin bad++; $display("FAIL simul_prod%0d got=%h want=%h", k, bus.resp_product, prod[order[k]]); end
        end
        bus.req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_fairness();
        logic [3:0]  rr, rv;
        bit          ok;
        int          order [4] = '{1, 3, 1, 3};
        logic [63:0] prod  [4] = '{64'd0, 64'd42, 64'd0, 64'd81};
        set_req(1, 32'd6, 32'd7);
        set_req(3, 32'd9, 32'd9);
        bus.req_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            wait_ready(rr, ok);
            total++; if (!ok || rr !== (4'b1 << order[k])) begin bad++; $display("FAIL fair_grant%0d got=%b want=%b", k, rr, 4'b1 << order[k]); end
            wait_resp(rv, ok);
            total++; if (!ok || bus.resp_product !== prod[order[k]]) begin bad++; $display("FAIL fair_prod%0d got=%0d want=%0d", k, bus.resp_product, prod[order[k]]); end
        end
        bus.req_valid = '0;
        @(negedge clk);
    endtask

    task automatic test_operand_stability();
        logic [3:0] rr, rv;
        bit ok;
        set_req(0, 32'd1234, 32'd5678);
        bus.req_valid = 4'b0001;
        wait_ready(rr, ok);
        bus.req_valid = '0;
        total++; if (!ok || rr !== 4'b0001) begin bad++; $display("FAIL stab_ready got=%b want=0001", rr); end
        repeat (10) @(negedge clk);
        bus.req_a[31:0] = 32'hDEAD_BEEF;
        @(negedge clk);
        total++; if (dut.u_mult.a !== 32'd1234) begin bad++; $display("FAIL stab_mult_a got=%h want=%h", dut.u_mult.a, 32'd1234); end
        wait_resp(rv, ok);
        total++; if (!ok || bus.resp_product !== 64'd7006652) begin bad++; $display("FAIL stab_prod got=%0d want=7006652", bus.resp_product); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        logic [3:0] rr, rv;
        bit ok;
        int seen;
        set_req(3, 32'd3, 32'd3);
        bus.req_valid = 4'b1000;
        wait_ready(rr, ok);
        bus.req_valid = '0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if (bus.arb_busy !== 1'b0) begin bad++; $display("FAIL rmid_busy got=%b want=0", bus.arb_busy); end
        total++; if (bus.req_ready !== 4'b0 || bus.resp_valid !== 4'b0) begin bad++; $display("FAIL rmid_pulses got=%b/%b want=0000/0000", bus.req_ready, bus.resp_valid); end
        total++; if (bus.resp_product !== 64'd0) begin bad++; $display("FAIL rmid_product got=%0d want=0", bus.resp_product); end
        @(negedge clk);
        reset = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.resp_valid != 4'b0) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL rmid_no_resp got=%0d want=0", seen); end
        set_req(0, 32'd11, 32'd13);
        set_req(2, 32'd17, 32'd19);
        bus.req_valid = 4'b0101;
        wait_ready(rr, ok);
        bus.req_valid = '0;
        total++; if (!ok || rr !== 4'b0001) begin bad++; $display("FAIL rmid_first_grant got=%b want=0001", rr); end
        wait_resp(rv, ok);
        total++; if (!ok || bus.resp_product !== 64'd143 || bus.resp_idx !== 2'd0) begin bad++; $display("FAIL rmid_prod got=%0d idx=%0d want=143 idx=0", bus.resp_product, bus.resp_idx); end
    endtask

    initial begin
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        test_reset();
        test_single();
        test_full_width();
        test_simultaneous();
        test_fairness();
        test_operand_stability();
        test_reset_mid_op();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
